// File: rtl/riscv_fetch_unit_pkg.sv
// Shared definitions for the RV32I fetch front end: widths, reset vector and the NOP
// encoding that downstream stages insert on a flush.
package riscv_fetch_unit_pkg;

    localparam int unsigned DEFAULT_XLEN     = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int unsigned ILEN             = 32;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

endpackage

// File: rtl/riscv_fetch_unit_sync_fifo.sv
// Synchronous FIFO used as the fetch queue; flush empties it in one cycle and wins over
// any push or pop in the same cycle.
module sync_fifo
    import riscv_fetch_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage is not reset; only the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
        mem_q <= mem_d;
    end

endmodule

// File: rtl/riscv_fetch_unit.sv
// Decoupled instruction fetch engine: issues word fetches to a variable-latency memory,
// buffers responses in a FIFO and discards stale responses after an EX redirect.
module riscv_fetch_unit
    import riscv_fetch_unit_pkg::*;
#(
    parameter int unsigned     XLEN            = DEFAULT_XLEN,
    parameter logic [XLEN-1:0] RESET_PC        = XLEN'(DEFAULT_RESET_PC),
    parameter int unsigned     FQ_DEPTH        = 4,
    parameter int unsigned     MAX_OUTSTANDING = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            fq_out_valid,
    input  logic            fq_out_ready,
    output logic [XLEN-1:0] fq_out_pc,
    output logic [ILEN-1:0] fq_out_instr
);

    localparam int unsigned FQ_CNT_W = $clog2(FQ_DEPTH + 1);
    localparam int unsigned CNT_W    = $clog2(FQ_DEPTH + 1) + 1;
    localparam int unsigned FQ_W     = XLEN + ILEN;

    logic [XLEN-1:0]     fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]     resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0]    outstanding_q, outstanding_d;
    logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0]    live_cnt;
    logic [CNT_W-1:0]    credit_used;
    logic [FQ_CNT_W-1:0] fq_count;
    logic                fq_full;
    logic                fq_empty;
    logic                fq_push;
    logic                fq_pop;
    logic [FQ_W-1:0]     fq_wdata;
    logic [FQ_W-1:0]     fq_rdata;
    logic                req_accept;
    logic                rsp_seen;
    logic                rsp_drop;
    logic [XLEN-1:0]     redirect_target;
    logic                unused_redirect_bits;

    assign redirect_target      = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_redirect_bits = ^redirect_pc[1:0];

    // Queue slots are reserved for every live request, so a response always finds room.
    assign live_cnt    = outstanding_q - drop_cnt_q;
    assign credit_used = CNT_W'(fq_count) + live_cnt;

    assign imem_req_valid = !rst && !redirect_valid
                            && (outstanding_q < CNT_W'(MAX_OUTSTANDING))
                            && (credit_used < CNT_W'(FQ_DEPTH));
    assign imem_req_addr  = rst ? RESET_PC : fetch_pc_q;
    assign req_accept     = imem_req_valid && imem_req_ready;

    assign rsp_seen = imem_rsp_valid && (outstanding_q != '0);
    assign rsp_drop = rsp_seen && (drop_cnt_q != '0);
    assign fq_push  = rsp_seen && !rsp_drop && !redirect_valid && !rst;
    assign fq_wdata = {resp_pc_q, imem_rsp_data};

    assign fq_out_valid = !rst && !fq_empty && !redirect_valid;
    assign fq_pop       = fq_out_valid && fq_out_ready;
    assign fq_out_pc    = fq_rdata[FQ_W-1:ILEN];
    assign fq_out_instr = fq_out_valid ? fq_rdata[ILEN-1:0] : NOP_INSTR;

    sync_fifo #(
        .WIDTH (FQ_W),
        .DEPTH (FQ_DEPTH)
    ) u_fetch_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (fq_push),
        .pop   (fq_pop),
        .flush (redirect_valid),
        .wdata (fq_wdata),
        .rdata (fq_rdata),
        .count (fq_count),
        .full  (fq_full),
        .empty (fq_empty)
    );

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        drop_cnt_d    = drop_cnt_q;
        outstanding_d = outstanding_q + CNT_W'(req_accept) - CNT_W'(rsp_seen);
        if (req_accept) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
        end
        if (fq_push) begin
            resp_pc_d = resp_pc_q + XLEN'(4);
        end
        if (rsp_drop) begin
            drop_cnt_d = drop_cnt_q - CNT_W'(1);
        end
        // Every request still in flight after this edge belongs to the old path.
        if (redirect_valid) begin
            fetch_pc_d = redirect_target;
            resp_pc_d  = redirect_target;
            drop_cnt_d = outstanding_q - CNT_W'(rsp_seen);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(fq_push && fq_full));
        end
    end

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Directed bench for riscv_fetch_unit: a variable-latency memory model plus tables of
// per-cycle stimulus and hand-computed expected outputs.
module tb_riscv_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fq_out_valid;
    logic        fq_out_ready;
    logic [31:0] fq_out_pc;
    logic [31:0] fq_out_instr;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_req_t;

    typedef struct {
        logic        rdv;
        logic [31:0] rpc;
        logic        fq_rdy;
        logic        req_rdy;
        logic        exp_req_v;
        logic [31:0] exp_addr;
        logic        exp_fq_v;
        logic [31:0] exp_pc;
    } vec_t;

    mem_req_t mem_q[$];
    vec_t     vq[$];
    int       mem_lat;
    int       cyc;
    int       checks;
    int       errors;

    riscv_fetch_unit #(
        .XLEN            (32),
        .RESET_PC        (32'h0000_0000),
        .FQ_DEPTH        (4),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fq_out_valid   (fq_out_valid),
        .fq_out_ready   (fq_out_ready),
        .fq_out_pc      (fq_out_pc),
        .fq_out_instr   (fq_out_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    function automatic vec_t mk(input logic rdv, input logic [31:0] rpc, input logic fq_rdy,
                                input logic req_rdy, input logic exp_req_v,
                                input logic [31:0] exp_addr, input logic exp_fq_v,
                                input logic [31:0] exp_pc);
        vec_t v;
        v.rdv       = rdv;
        v.rpc       = rpc;
        v.fq_rdy    = fq_rdy;
        v.req_rdy   = req_rdy;
        v.exp_req_v = exp_req_v;
        v.exp_addr  = exp_addr;
        v.exp_fq_v  = exp_fq_v;
        v.exp_pc    = exp_pc;
        return v;
    endfunction

    task automatic applyStimulus(input logic rdv, input logic [31:0] rpc,
                                 input logic fq_rdy, input logic req_rdy);
        redirect_valid = rdv;
        redirect_pc    = rpc;
        fq_out_ready   = fq_rdy;
        imem_req_ready = req_rdy;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic exp_req_v, input logic chk_addr,
                               input logic [31:0] exp_addr, input logic exp_fq_v,
                               input logic [31:0] exp_pc);
        checks++;
        if (imem_req_valid !== exp_req_v) begin
            errors++;
            $display("[TB] FAIL %s req_valid: got %b expected %b", name, imem_req_valid, exp_req_v);
        end
        if (chk_addr) begin
            checks++;
            if (imem_req_addr !== exp_addr) begin
                errors++;
                $display("[TB] FAIL %s req_addr: got %h expected %h", name, imem_req_addr, exp_addr);
            end
        end
        checks++;
        if (fq_out_valid !== exp_fq_v) begin
            errors++;
            $display("[TB] FAIL %s fq_valid: got %b expected %b", name, fq_out_valid, exp_fq_v);
        end
        if (exp_fq_v) begin
            checks++;
            if (fq_out_pc !== exp_pc) begin
                errors++;
                $display("[TB] FAIL %s fq_pc: got %h expected %h", name, fq_out_pc, exp_pc);
            end
            checks++;
            if (fq_out_instr !== instr_of(exp_pc)) begin
                errors++;
                $display("[TB] FAIL %s fq_instr: got %h expected %h", name, fq_out_instr,
                         instr_of(exp_pc));
            end
        end
    endtask

    // One clock: record acceptance, advance the memory model, then drive the response
    // for the next cycle at the falling edge.
    task automatic clockCycle();
        logic        acc;
        logic [31:0] acc_addr;
        mem_req_t    r;
        acc      = imem_req_valid && imem_req_ready;
        acc_addr = imem_req_addr;
        @(posedge clk);
        if (rst) begin
            mem_q.delete();
        end else begin
            if (imem_rsp_valid && mem_q.size() > 0) void'(mem_q.pop_front());
            if (acc) begin
                r.addr = acc_addr;
                r.due  = cyc + mem_lat;
                mem_q.push_back(r);
            end
        end
        cyc++;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (!rst && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instr_of(mem_q[0].addr);
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
            checkOutput("reset", 1'b0, 1'b1, 32'h0, 1'b0, 32'h0);
            clockCycle();
        end
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic runVectors(input string tag);
        for (int i = 0; i < vq.size(); i++) begin
            applyStimulus(vq[i].rdv, vq[i].rpc, vq[i].fq_rdy, vq[i].req_rdy);
            checkOutput($sformatf("%s[%0d]", tag, i), vq[i].exp_req_v, vq[i].exp_req_v,
                        vq[i].exp_addr, vq[i].exp_fq_v, vq[i].exp_pc);
            clockCycle();
        end
        vq.delete();
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        cyc            = 0;
        mem_lat        = 1;
        rst            = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        fq_out_ready   = 1'b1;
        imem_req_ready = 1'b1;

        // Free-run from reset, then a redirect with nothing left to drop.
        doReset();
        vq.push_back(mk(0, 32'h0,   1, 1, 1, 32'h000, 0, 32'h000));
        vq.push_back(mk(0, 32'h0,   1, 1, 1, 32'h004, 0, 32'h000));
        vq.push_back(mk(0, 32'h0,   1, 1, 1, 32'h008, 1, 32'h000));
        vq.push_back(mk(0, 32'h0,   1, 1, 1, 32'h00C, 1, 32'h004));
        vq.push_back(mk(0, 32'h0,   1, 1, 1, 32'h010, 1, 32'h008));
        vq.push_back(mk(1, 32'h203, 1, 1, 0, 32'h000, 0, 32'h000));
        vq.push_back(mk(0, 32'h0,   1, 1, 1, 32'h200, 0, 32'h000));
        vq.push_back(mk(0, 32'h0,   1, 1, 1, 32'h204, 0, 32'h000));
        vq.push_back(mk(0, 32'h0,   1, 1, 1, 32'h208, 1, 32'h200));
        vq.push_back(mk(0, 32'h0,   1, 1, 1, 32'h20C, 1, 32'h204));
        runVectors("freerun");

        // Decode stalls for ten cycles, queue fills with 0..C, then drains.
        doReset();
        for (int c = 0; c < 10; c++) begin
            vq.push_back(mk(0, 32'h0, 0, 1, c < 4, 32'(c * 4), c >= 2, 32'h0));
        end
        vq.push_back(mk(0, 32'h0, 1, 1, 0, 32'h000, 1, 32'h000));
        vq.push_back(mk(0, 32'h0, 1, 1, 1, 32'h010, 1, 32'h004));
        vq.push_back(mk(0, 32'h0, 1, 1, 1, 32'h014, 1, 32'h008));
        vq.push_back(mk(0, 32'h0, 1, 1, 1, 32'h018, 1, 32'h00C));
        vq.push_back(mk(0, 32'h0, 1, 1, 1, 32'h01C, 1, 32'h010));
        runVectors("stall");

        // Three-cycle memory: redirect while two requests are in flight.
        mem_lat = 3;
        doReset();
        vq.push_back(mk(0, 32'h0,   1, 1, 1, 32'h000, 0, 32'h000));
        vq.push_back(mk(0, 32'h0,   1, 1, 1, 32'h004, 0, 32'h000));
        vq.push_back(mk(1, 32'h102, 1, 1, 0, 32'h000, 0, 32'h000));
        vq.push_back(mk(0, 32'h0,   1, 1, 0, 32'h000, 0, 32'h000));
        vq.push_back(mk(0, 32'h0,   1, 1, 1, 32'h100, 0, 32'h000));
        vq.push_back(mk(0, 32'h0,   1, 1, 1, 32'h104, 0, 32'h000));
        vq.push_back(mk(0, 32'h0,   1, 1, 0, 32'h000, 0, 32'h000));
        vq.push_back(mk(0, 32'h0,   1, 1, 0, 32'h000, 0, 32'h000));
        vq.push_back(mk(0, 32'h0,   1, 1, 1, 32'h108, 1, 32'h100));
        vq.push_back(mk(0, 32'h0,   1, 1, 1, 32'h10C, 1, 32'h104));
        runVectors("drop");

        // Redirect in the same cycle as a response and a pop, two entries queued.
        mem_lat = 1;
        doReset();
        vq.push_back(mk(0, 32'h0,  0, 1, 1, 32'h000, 0, 32'h000));
        vq.push_back(mk(0, 32'h0,  0, 1, 1, 32'h004, 0, 32'h000));
        vq.push_back(mk(0, 32'h0,  0, 1, 1, 32'h008, 1, 32'h000));
        vq.push_back(mk(1, 32'h40, 1, 1, 0, 32'h000, 0, 32'h000));
        vq.push_back(mk(0, 32'h0,  1, 1, 1, 32'h040, 0, 32'h000));
        vq.push_back(mk(0, 32'h0,  1, 1, 1, 32'h044, 0, 32'h000));
        vq.push_back(mk(0, 32'h0,  1, 1, 1, 32'h048, 1, 32'h040));
        vq.push_back(mk(0, 32'h0,  1, 1, 1, 32'h04C, 1, 32'h044));
        runVectors("coincide");

        // Memory not ready for five cycles: request held, accepted once.
        doReset();
        for (int c = 0; c < 5; c++) begin
            vq.push_back(mk(0, 32'h0, 1, 0, 1, 32'h000, 0, 32'h000));
        end
        vq.push_back(mk(0, 32'h0, 1, 1, 1, 32'h000, 0, 32'h000));
        vq.push_back(mk(0, 32'h0, 1, 1, 1, 32'h004, 0, 32'h000));
        vq.push_back(mk(0, 32'h0, 1, 1, 1, 32'h008, 1, 32'h000));
        vq.push_back(mk(0, 32'h0, 1, 1, 1, 32'h00C, 1, 32'h004));
        runVectors("reqstall");

        // Address wrap through all-ones; low redirect bits must be ignored.
        doReset();
        vq.push_back(mk(1, 32'hFFFF_FFFB, 1, 1, 0, 32'h0,         0, 32'h0));
        vq.push_back(mk(0, 32'h0,         1, 1, 1, 32'hFFFF_FFF8, 0, 32'h0));
        vq.push_back(mk(0, 32'h0,         1, 1, 1, 32'hFFFF_FFFC, 0, 32'h0));
        vq.push_back(mk(0, 32'h0,         1, 1, 1, 32'h0000_0000, 1, 32'hFFFF_FFF8));
        vq.push_back(mk(0, 32'h0,         1, 1, 1, 32'h0000_0004, 1, 32'hFFFF_FFFC));
        vq.push_back(mk(0, 32'h0,         1, 1, 1, 32'h0000_0008, 1, 32'h0000_0000));
        vq.push_back(mk(0, 32'h0,         1, 1, 1, 32'h0000_000C, 1, 32'h0000_0004));
        runVectors("wrap");

        // Reset while the queue holds entries, then restart from the reset vector.
        doReset();
        vq.push_back(mk(0, 32'h0, 1, 1, 1, 32'h000, 0, 32'h000));
        vq.push_back(mk(0, 32'h0, 1, 1, 1, 32'h004, 0, 32'h000));
        vq.push_back(mk(0, 32'h0, 1, 1, 1, 32'h008, 1, 32'h000));
        runVectors("rerun");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
